// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - handshake/status bundle for fifo_sync_param
// Ports (signals):
//   FLUSH, WREN, DI, RDEN              - requests and write data toward the FIFO
//   DO, EMPTY, FULL, ALMOSTEMPTY,
//   ALMOSTFULL, COUNT, WRERR, RDERR,
//   OVF_STICKY, UDF_STICKY             - read data and status from the FIFO
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  FLUSH;
    logic                  WREN;
    logic [DATA_WIDTH-1:0] DI;
    logic                  RDEN;
    logic [DATA_WIDTH-1:0] DO;
    logic                  EMPTY;
    logic                  FULL;
    logic                  ALMOSTEMPTY;
    logic                  ALMOSTFULL;
    logic [CW-1:0]         COUNT;
    logic                  WRERR;
    logic                  RDERR;
    logic                  OVF_STICKY;
    logic                  UDF_STICKY;

    modport master (
        output FLUSH, WREN, DI, RDEN,
        input  DO, EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL, COUNT,
               WRERR, RDERR, OVF_STICKY, UDF_STICKY
    );

    modport slave (
        input  FLUSH, WREN, DI, RDEN,
        output DO, EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL, COUNT,
               WRERR, RDERR, OVF_STICKY, UDF_STICKY
    );
endinterface

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with FWFT and output-register modes
// Ports:
//   CLK   - clock, all state on the rising edge
//   RST_N - asynchronous active-low reset
//   bus   - fifo_sync_param_if.slave: FLUSH/WREN/DI/RDEN in; DO, EMPTY, FULL,
//           ALMOSTEMPTY, ALMOSTFULL, COUNT, WRERR, RDERR, OVF_STICKY, UDF_STICKY out
module fifo_sync_param #(
    parameter int DATA_WIDTH          = 8,
    parameter int DEPTH               = 16,
    parameter int ALMOST_EMPTY_OFFSET = 2,
    parameter int ALMOST_FULL_OFFSET  = 2,
    parameter int FWFT                = 0,
    parameter int DO_REG              = 0
) (
    input logic               CLK,
    input logic               RST_N,
    fifo_sync_param_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam bit USE_FWFT  = (FWFT != 0);
    localparam bit USE_DOREG = (DO_REG != 0) && !USE_FWFT;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_OFFSET);
    localparam logic [CW-1:0] AF_C    = CW'(DEPTH - ALMOST_FULL_OFFSET);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    generate
        if (DEPTH < 4 || DEPTH > 65536 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fifo_sync_param: DEPTH must be a power of two in 4..65536");
        end
        if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_bad_width
            $error("fifo_sync_param: DATA_WIDTH must be in 1..1024");
        end
        if (ALMOST_EMPTY_OFFSET < 0 || ALMOST_EMPTY_OFFSET >= DEPTH) begin : g_bad_ae
            $error("fifo_sync_param: ALMOST_EMPTY_OFFSET must be < DEPTH");
        end
        if (ALMOST_FULL_OFFSET < 0 || ALMOST_FULL_OFFSET >= DEPTH) begin : g_bad_af
            $error("fifo_sync_param: ALMOST_FULL_OFFSET must be < DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  aempty_q, aempty_d;
    logic                  afull_q, afull_d;
    logic                  wrerr_q, wrerr_d;
    logic                  rderr_q, rderr_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    // s1 is the read stage in standard mode and the prefetch word in FWFT mode
    logic [DATA_WIDTH-1:0] s1_q, s1_d;
    logic                  s1_vld_q, s1_vld_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  pf_vld_q, pf_vld_d;

    logic                  wr_ok, rd_ok, mem_we, mem_nonempty;
    logic [DATA_WIDTH-1:0] rd_word;

    always_comb begin
        wr_ok        = bus.WREN && !full_q;
        rd_ok        = bus.RDEN && !empty_q;
        mem_we       = wr_ok && !bus.FLUSH;
        mem_nonempty = (wr_ptr_q != rd_ptr_q);
        rd_word      = mem_q[rd_ptr_q[AW-1:0]];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        s1_d     = s1_q;
        s1_vld_d = 1'b0;
        dout_d   = dout_q;
        pf_vld_d = pf_vld_q;

        wrerr_d = bus.WREN && full_q;
        rderr_d = bus.RDEN && empty_q;
        ovf_d   = ovf_q || wrerr_d;
        udf_d   = udf_q || rderr_d;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        if (USE_FWFT) begin
            // A pop frees the prefetch slot, so the next memory word can be
            // loaded on the same edge and pops stream one per cycle.
            pf_vld_d = pf_vld_q && !rd_ok;
            if (mem_nonempty && (!pf_vld_q || rd_ok)) begin
                s1_d     = rd_word;
                rd_ptr_d = rd_ptr_q + ONE_C;
                pf_vld_d = 1'b1;
            end
            empty_d = !pf_vld_d;
        end else begin
            if (rd_ok) begin
                s1_d     = rd_word;
                rd_ptr_d = rd_ptr_q + ONE_C;
            end
            s1_vld_d = rd_ok;
            // Second stage only advances on a real read so DO holds otherwise
            if (s1_vld_q) begin
                dout_d = s1_q;
            end
            empty_d = (count_d == '0);
        end

        full_d   = (count_d == DEPTH_C);
        aempty_d = (count_d <= AE_C);
        afull_d  = (count_d >= AF_C);

        if (bus.FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            empty_d  = 1'b1;
            full_d   = 1'b0;
            aempty_d = 1'b1;
            afull_d  = 1'b0;
            wrerr_d  = 1'b0;
            rderr_d  = 1'b0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
            s1_d     = '0;
            s1_vld_d = 1'b0;
            dout_d   = '0;
            pf_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.DI;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            wrerr_q  <= 1'b0;
            rderr_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            dout_q   <= '0;
            pf_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            wrerr_q  <= wrerr_d;
            rderr_q  <= rderr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            s1_q     <= s1_d;
            s1_vld_q <= s1_vld_d;
            dout_q   <= dout_d;
            pf_vld_q <= pf_vld_d;
        end
    end

    assign bus.DO          = USE_DOREG ? dout_q : s1_q;
    assign bus.EMPTY       = empty_q;
    assign bus.FULL        = full_q;
    assign bus.ALMOSTEMPTY = aempty_q;
    assign bus.ALMOSTFULL  = afull_q;
    assign bus.COUNT       = count_q;
    assign bus.WRERR       = wrerr_q;
    assign bus.RDERR       = rderr_q;
    assign bus.OVF_STICKY  = ovf_q;
    assign bus.UDF_STICKY  = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - scoreboard bench for fifo_sync_param in standard, DO_REG and FWFT modes
module tb_fifo_sync_param;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wren  = 1'b0;
    logic          rden  = 1'b0;
    logic [DW-1:0] di    = '0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if_std ();
    fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if_reg ();
    fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) if_fw ();

    assign if_std.FLUSH = flush;
    assign if_std.WREN  = wren;
    assign if_std.RDEN  = rden;
    assign if_std.DI    = di;
    assign if_reg.FLUSH = flush;
    assign if_reg.WREN  = wren;
    assign if_reg.RDEN  = rden;
    assign if_reg.DI    = di;
    assign if_fw.FLUSH  = flush;
    assign if_fw.WREN   = wren;
    assign if_fw.RDEN   = rden;
    assign if_fw.DI     = di;

    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .DO_REG(0)) u_std (
        .CLK(clk), .RST_N(rst_n), .bus(if_std));
    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .DO_REG(1)) u_reg (
        .CLK(clk), .RST_N(rst_n), .bus(if_reg));
    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .DO_REG(0)) u_fw (
        .CLK(clk), .RST_N(rst_n), .bus(if_fw));

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // standard-mode model (shared by the DO_REG=0 and DO_REG=1 instances)
    int            cnt_s;
    logic [DW-1:0] mem_s[$];
    logic [DW-1:0] do0_e, do1_e;
    logic [DW-1:0] pend_v[$];
    int            pend_t[$];
    logic          wrerr_s, rderr_s, ovf_s, udf_s;

    // FWFT model
    int            cnt_f;
    logic [DW-1:0] mem_f[$];
    logic          pf_v;
    logic [DW-1:0] pf_d;
    logic          wrerr_f, rderr_f, ovf_f, udf_f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        cnt_s = 0; mem_s.delete(); pend_v.delete(); pend_t.delete();
        do0_e = '0; do1_e = '0;
        wrerr_s = 0; rderr_s = 0; ovf_s = 0; udf_s = 0;
        cnt_f = 0; mem_f.delete(); pf_v = 0; pf_d = '0;
        wrerr_f = 0; rderr_f = 0; ovf_f = 0; udf_f = 0;
    endtask

    task automatic model_step();
        bit ws, rs, wf, rf, had_mem;
        logic [DW-1:0] v;
        cyc++;
        if (flush) begin
            model_reset();
            return;
        end
        ws = wren && (cnt_s < DEPTH);
        rs = rden && (cnt_s > 0);
        wrerr_s = wren && !ws;
        rderr_s = rden && !rs;
        ovf_s   = ovf_s | wrerr_s;
        udf_s   = udf_s | rderr_s;
        if (pend_t.size() > 0 && pend_t[0] == cyc) begin
            do1_e = pend_v.pop_front();
            void'(pend_t.pop_front());
        end
        if (rs) begin
            v = mem_s.pop_front();
            do0_e = v;
            pend_v.push_back(v);
            pend_t.push_back(cyc + 1);
        end
        if (ws) mem_s.push_back(di);
        cnt_s = cnt_s + int'(ws) - int'(rs);

        wf = wren && (cnt_f < DEPTH);
        rf = rden && pf_v;
        wrerr_f = wren && !wf;
        rderr_f = rden && !rf;
        ovf_f   = ovf_f | wrerr_f;
        udf_f   = udf_f | rderr_f;
        had_mem = (mem_f.size() > 0);
        if (rf) pf_v = 0;
        if (had_mem && !pf_v) begin
            pf_d = mem_f.pop_front();
            pf_v = 1;
        end
        if (wf) mem_f.push_back(di);
        cnt_f = cnt_f + int'(wf) - int'(rf);
    endtask

    task automatic chk_dut(input string n, input logic [4:0] count, input logic empty, full,
                           ae, af, we, re, ovf, udf, input int cnt_e, input logic empty_e,
                           we_e, re_e, ovf_e, udf_e);
        check({n, "_count"}, count, cnt_e);
        check({n, "_empty"}, empty, empty_e);
        check({n, "_full"},  full,  cnt_e == DEPTH);
        check({n, "_aempty"}, ae,   cnt_e <= 2);
        check({n, "_afull"}, af,    cnt_e >= DEPTH - 2);
        check({n, "_wrerr"}, we,    we_e);
        check({n, "_rderr"}, re,    re_e);
        check({n, "_ovf"},   ovf,   ovf_e);
        check({n, "_udf"},   udf,   udf_e);
    endtask

    task automatic check_all();
        chk_dut("std", if_std.COUNT, if_std.EMPTY, if_std.FULL, if_std.ALMOSTEMPTY,
                if_std.ALMOSTFULL, if_std.WRERR, if_std.RDERR, if_std.OVF_STICKY,
                if_std.UDF_STICKY, cnt_s, cnt_s == 0, wrerr_s, rderr_s, ovf_s, udf_s);
        chk_dut("reg", if_reg.COUNT, if_reg.EMPTY, if_reg.FULL, if_reg.ALMOSTEMPTY,
                if_reg.ALMOSTFULL, if_reg.WRERR, if_reg.RDERR, if_reg.OVF_STICKY,
                if_reg.UDF_STICKY, cnt_s, cnt_s == 0, wrerr_s, rderr_s, ovf_s, udf_s);
        chk_dut("fw", if_fw.COUNT, if_fw.EMPTY, if_fw.FULL, if_fw.ALMOSTEMPTY,
                if_fw.ALMOSTFULL, if_fw.WRERR, if_fw.RDERR, if_fw.OVF_STICKY,
                if_fw.UDF_STICKY, cnt_f, !pf_v, wrerr_f, rderr_f, ovf_f, udf_f);
        check("std_do", if_std.DO, do0_e);
        check("reg_do", if_reg.DO, do1_e);
        if (pf_v) check("fw_do", if_fw.DO, pf_d);
    endtask

    task automatic cycle(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
        flush = f; wren = w; rden = r; di = d;
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        check("fw_do_reset", if_fw.DO, 0);
        rst_n = 1'b1;

        // fill to full, then one overflow write
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));
        cycle(1'b0, 1'b1, 1'b0, 8'h10);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // drain, plus one underflow read
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // FWFT latency and streaming
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'hA5);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h11);
        cycle(1'b0, 1'b1, 1'b0, 8'h22);
        cycle(1'b0, 1'b1, 1'b0, 8'h33);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);

        // pointer wrap with simultaneous read/write at COUNT=8
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, DW'(8'h40 + i));
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b1, DW'($urandom));

        // COUNT=9 then FLUSH with both requests high
        cycle(1'b0, 1'b1, 1'b0, 8'h99);
        cycle(1'b1, 1'b1, 1'b1, 8'h77);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // asynchronous reset in the middle of a write burst
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, DW'(8'h50 + i));
        flush = 1'b0; wren = 1'b1; rden = 1'b0; di = 8'h5A;
        @(posedge clk);
        model_step();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        check("fw_do_async_reset", if_fw.DO, 0);
        @(negedge clk);
        wren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 8'h3C);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("std_do_3c", if_std.DO, 8'h3C);
        check("reg_do_3c", if_reg.DO, 8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
